sdp_pipe: RTL and testbench
===========================

SDP_PIPE -- requirements
Module: sdp_pipe

Interface
REQ-001 SHALL have parameter W_DATA, default 16, read/write data width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter W_ADDR, default 10, address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words; DEPTH <= 2**W_ADDR.
REQ-004 SHALL have parameter RD_LAT, default 2, read latency in cycles, legal range 1..4.
REQ-005 SHALL have parameter COLLISION, default READ_FIRST, same-address policy, values READ_FIRST | WRITE_FIRST.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_addr_data  dti.consumer  W_DATA/8+W_DATA+W_ADDR  packed {be, data, addr}, addr in LSBs.
REQ-009 SHALL have port rd_addr  dti.consumer  W_ADDR  read address.
REQ-010 SHALL have port rd_data  dti.producer  W_DATA  read data, in address-acceptance order.

Function
REQ-011 SHALL drive wr_addr_data.ready constant 1; a write SHALL occur in the cycle in which valid=1.
REQ-012 SHALL write only bytes whose be bit is 1; be=0 SHALL leave the word unchanged.
REQ-013 SHALL ignore writes with addr >= DEPTH; reads with addr >= DEPTH SHALL return all zeros.
REQ-014 SHALL accept a read address when rd_addr.valid & rd_addr.ready.
REQ-015 SHALL keep an occupancy counter of reads accepted but not yet delivered, range 0..RD_LAT+1.
REQ-016 SHALL drive rd_addr.ready = (occupancy < RD_LAT+1), from registers only; there SHALL be no combinational path from rd_data.ready.
REQ-017 SHALL present a read accepted in cycle N on rd_data in cycle N+RD_LAT when no earlier data is pending; otherwise it SHALL follow the pending data in order.
REQ-018 SHALL sustain one read per cycle while rd_data.ready=1 continuously.
REQ-019 SHALL implement the read path as the memory output register plus RD_LAT-1 pipeline registers, each with a valid bit.
REQ-020 SHALL feed the pipeline into a fall-through output buffer of depth RD_LAT+1: when the buffer is empty, pipeline output drives rd_data directly; otherwise the buffer head drives it.
REQ-021 SHALL never drop or duplicate data; the buffer SHALL never overflow, guaranteed by REQ-016.
REQ-022 SHALL hold rd_data.data stable while valid=1 and ready=0.
REQ-023 SHALL, when occupancy increments and decrements in the same cycle, leave it unchanged.
REQ-024 SHALL, for a write and an accepted read to the same address in the same cycle with COLLISION=READ_FIRST, return the old word.
REQ-025 SHALL, in the REQ-024 case with COLLISION=WRITE_FIRST, return old bytes merged with the written bytes per be.
REQ-026 SHALL, for a write in a later cycle than an accepted read, not alter that read's returned data.

Reset
REQ-027 SHALL, with rst=1, clear all pipeline valid bits, empty the output buffer and set occupancy to 0 at the next edge.
REQ-028 SHALL, during and after reset, drive rd_data.valid=0 and rd_addr.ready=1 from the cycle after the reset edge.
REQ-029 SHALL discard in-flight reads on reset mid-operation; memory contents SHALL be unaffected by reset.
REQ-030 SHALL ignore writes presented while rst=1.

Structure
REQ-031 SHALL place the collision-policy enum and a parametrised write-port struct {be, data, addr} in shared package sdp_pkg.
REQ-032 SHALL implement the output buffer as sub-module sdp_pipe_obuf (params W_DATA, DEPTH_BUF) with push/pop/head/empty/count.
REQ-033 SHALL infer the memory array as block RAM: one write port, one registered read port, no reset on the array.

Verification
REQ-034 SHALL cover: RD_LAT=2, write 0xBEEF@5 at cycle 0, read 5 at cycle 2, rd_data.ready=1 -> rd_data.valid with 0xBEEF at cycle 4.
REQ-035 SHALL cover: RD_LAT=3, reads of addresses 0..7 back-to-back, ready=1 -> 8 consecutive valid beats, in order, no gaps.
REQ-036 SHALL cover: RD_LAT=2, 10 reads issued, rd_data.ready=0 for 6 cycles -> rd_addr.ready falls after 3 accepts, all 10 words later delivered in order.
REQ-037 SHALL cover: mem[3]=0x1234, same-cycle write 0xABCD be=2'b01 @3 and read @3 -> READ_FIRST returns 0x1234; WRITE_FIRST returns 0x12CD.
REQ-038 SHALL cover: rst pulsed with 2 reads in flight -> no rd_data beat for them, occupancy 0, rd_addr.ready=1 next cycle; a later read returns the pre-reset contents.
REQ-039 SHALL cover: DEPTH=1000, W_ADDR=10, write to addr 1010 then read 1010 -> read returns 0x0000, and no memory word is changed.

Source files
------------

// File: rtl/sdp_pkg.sv
// Shared types for the simple dual-port RAM pipeline: collision policy and
// the packed write-port layout {be, data, addr} at the default geometry.
package sdp_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } collision_e;

    localparam int DEF_W_DATA = 16;
    localparam int DEF_W_ADDR = 10;

    function automatic int be_width(input int w_data);
        return w_data / 8;
    endfunction

    // Default-geometry view of the write bus; the top slices the same layout
    // for any W_DATA/W_ADDR, address always in the LSBs.
    typedef struct packed {
        logic [DEF_W_DATA/8-1:0] be;
        logic [DEF_W_DATA-1:0]   data;
        logic [DEF_W_ADDR-1:0]   addr;
    } wr_port_t;

endpackage

// File: rtl/sdp_pipe_obuf.sv
// Fall-through output buffer: circular FIFO whose head is visible in the
// same cycle as empty deasserts.
module sdp_pipe_obuf #(
    parameter int W_DATA    = 16,
    parameter int DEPTH_BUF = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [W_DATA-1:0]                push_data,
    input  logic                             pop,
    output logic [W_DATA-1:0]                head,
    output logic                             empty,
    output logic [$clog2(DEPTH_BUF+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH_BUF > 1) ? $clog2(DEPTH_BUF) : 1;

    logic [W_DATA-1:0] mem [DEPTH_BUF];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH_BUF - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/sdp_pipe.sv
// Simple dual-port RAM with byte-enabled writes, a fixed-latency read
// pipeline and a fall-through output buffer absorbing rd_data back-pressure.
module sdp_pipe
    import sdp_pkg::*;
#(
    parameter int         W_DATA    = 16,
    parameter int         W_ADDR    = 10,
    parameter int         DEPTH     = 1024,
    parameter int         RD_LAT    = 2,
    parameter collision_e COLLISION = READ_FIRST
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_addr_data_valid,
    output logic                              wr_addr_data_ready,
    input  logic [W_DATA/8+W_DATA+W_ADDR-1:0] wr_addr_data,
    input  logic                              rd_addr_valid,
    output logic                              rd_addr_ready,
    input  logic [W_ADDR-1:0]                 rd_addr,
    output logic                              rd_data_valid,
    input  logic                              rd_data_ready,
    output logic [W_DATA-1:0]                 rd_data
);

    localparam int NB        = be_width(W_DATA);
    localparam int BUF_DEPTH = RD_LAT + 1;
    localparam int OCC_W     = $clog2(RD_LAT + 2);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [OCC_W-1:0]  OCC_MAX = OCC_W'(RD_LAT + 1);
    localparam logic [W_ADDR:0]   DEPTH_L = (W_ADDR + 1)'(DEPTH);

    if (W_DATA % 8 != 0) begin : g_bad_wdata
        $error("W_DATA must be a multiple of 8");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("RD_LAT must be in 1..4");
    end
    if (DEPTH > 2**W_ADDR) begin : g_bad_depth
        $error("DEPTH exceeds the address space");
    end

    // ---- write port ----
    logic [NB-1:0]     wr_be;
    logic [W_DATA-1:0] wr_din;
    logic [W_ADDR-1:0] wr_addr;
    logic              wr_en;

    assign wr_be   = wr_addr_data[W_ADDR+W_DATA +: NB];
    assign wr_din  = wr_addr_data[W_ADDR +: W_DATA];
    assign wr_addr = wr_addr_data[W_ADDR-1:0];
    assign wr_en   = wr_addr_data_valid && !rst && ({1'b0, wr_addr} < DEPTH_L);
    assign wr_addr_data_ready = 1'b1;

    logic [W_DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_din[b*8 +: 8];
            end
        end
    end

    // ---- read port: memory output register ----
    logic              rd_acc;
    logic              rd_oob;
    logic              wr_hit;
    logic              rdy_q;
    logic [W_DATA-1:0] ram_q;
    logic [W_DATA-1:0] byp_data;
    logic [NB-1:0]     byp_be;
    logic              oob_q;

    assign rd_acc = rd_addr_valid && rdy_q && !rst;
    assign rd_oob = ({1'b0, rd_addr} >= DEPTH_L);
    assign wr_hit = (COLLISION == WRITE_FIRST) && wr_en && (wr_addr == rd_addr);

    // The array read sees pre-write contents; same-cycle written bytes are
    // captured alongside and merged after the register so the RAM stays plain.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            ram_q    <= mem[rd_oob ? '0 : rd_addr];
            byp_be   <= wr_hit ? wr_be : '0;
            byp_data <= wr_din;
            oob_q    <= rd_oob;
        end
    end

    logic [W_DATA-1:0] s0_data;

    always_comb begin
        s0_data = ram_q;
        for (int b = 0; b < NB; b++) begin
            if (byp_be[b]) s0_data[b*8 +: 8] = byp_data[b*8 +: 8];
        end
        if (oob_q) s0_data = '0;
    end

    // ---- read pipeline: stage 0 is the memory register ----
    logic [RD_LAT-1:0] vld_pipe;
    logic              pipe_vld;
    logic [W_DATA-1:0] pipe_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            for (int s = 1; s < RD_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    assign pipe_vld = vld_pipe[RD_LAT-1];

    if (RD_LAT == 1) begin : g_lat1
        assign pipe_data = s0_data;
    end else begin : g_latn
        logic [W_DATA-1:0] dat_pipe [1:RD_LAT-1];

        always_ff @(posedge clk) begin
            dat_pipe[1] <= s0_data;
            for (int s = 2; s < RD_LAT; s++) dat_pipe[s] <= dat_pipe[s-1];
        end

        assign pipe_data = dat_pipe[RD_LAT-1];
    end

    // ---- output buffer ----
    logic              obuf_push;
    logic              obuf_pop;
    logic              obuf_empty;
    logic [W_DATA-1:0] obuf_head;
    logic [CNT_W-1:0]  obuf_count;

    assign obuf_pop      = !obuf_empty && rd_data_ready;
    assign obuf_push     = pipe_vld && !(obuf_empty && rd_data_ready);
    assign rd_data_valid = !obuf_empty || pipe_vld;
    assign rd_data       = obuf_empty ? pipe_data : obuf_head;

    sdp_pipe_obuf #(
        .W_DATA    (W_DATA),
        .DEPTH_BUF (BUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (obuf_push),
        .push_data (pipe_data),
        .pop       (obuf_pop),
        .head      (obuf_head),
        .empty     (obuf_empty),
        .count     (obuf_count)
    );

    // Credit limit on rd_addr guarantees the buffer can always take a push.
    assert property (@(posedge clk) disable iff (rst)
        !(obuf_push && !obuf_pop && obuf_count == CNT_W'(BUF_DEPTH)));

    // ---- occupancy and registered address ready ----
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic             deliver;

    assign deliver = rd_data_valid && rd_data_ready;

    always_comb begin
        occ_next = occ;
        if (rd_acc && !deliver)      occ_next = occ + OCC_W'(1);
        else if (!rd_acc && deliver) occ_next = occ - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ   <= '0;
            rdy_q <= 1'b1;
        end else begin
            occ   <= occ_next;
            rdy_q <= (occ_next < OCC_MAX);
        end
    end

    assign rd_addr_ready = rdy_q;

endmodule

// File: tb/tb_sdp_pipe.sv
// Two sdp_pipe configurations checked cycle by cycle against a queue/array
// model of the memory and of in-order delivery, plus directed scenarios.
module tb_sdp_pipe;
    import sdp_pkg::*;

    localparam int W_DATA = 16;
    localparam int W_ADDR = 10;
    localparam int WW     = W_DATA/8 + W_DATA + W_ADDR;

    function automatic int lat_of(input int i);   return (i == 0) ? 2 : 3;       endfunction
    function automatic int depth_of(input int i); return (i == 0) ? 1000 : 1024; endfunction
    function automatic bit wf_of(input int i);    return (i == 1);               endfunction

    logic              clk;
    logic              rst;
    logic              wv;
    logic [WW-1:0]     wbus;
    logic              wrdy [2];
    logic              rv   [2];
    logic              ardy [2];
    logic [W_ADDR-1:0] ra   [2];
    logic              dv   [2];
    logic              rr   [2];
    logic [W_DATA-1:0] dd   [2];

    sdp_pipe #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .DEPTH(1000), .RD_LAT(2),
               .COLLISION(READ_FIRST)) dut0 (
        .clk(clk), .rst(rst),
        .wr_addr_data_valid(wv), .wr_addr_data_ready(wrdy[0]), .wr_addr_data(wbus),
        .rd_addr_valid(rv[0]), .rd_addr_ready(ardy[0]), .rd_addr(ra[0]),
        .rd_data_valid(dv[0]), .rd_data_ready(rr[0]), .rd_data(dd[0]));

    sdp_pipe #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .DEPTH(1024), .RD_LAT(3),
               .COLLISION(WRITE_FIRST)) dut1 (
        .clk(clk), .rst(rst),
        .wr_addr_data_valid(wv), .wr_addr_data_ready(wrdy[1]), .wr_addr_data(wbus),
        .rd_addr_valid(rv[1]), .rd_addr_ready(ardy[1]), .rd_addr(ra[1]),
        .rd_data_valid(dv[1]), .rd_data_ready(rr[1]), .rd_data(dd[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---- reference model ----
    typedef struct { int avail; logic [W_DATA-1:0] data; } exp_t;
    typedef struct { int cyc;   logic [W_DATA-1:0] data; } beat_t;

    exp_t              eq   [2][$];
    beat_t             blog [2][$];
    logic [W_DATA-1:0] mm   [2][1024];
    int                acc_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        wr_port_t w;
        w = wbus;
        for (int i = 0; i < 2; i++) begin
            bit                ev;
            logic [W_DATA-1:0] ed;
            ev = (eq[i].size() > 0) && (eq[i][0].avail <= cyc);
            chk($sformatf("dut%0d wr_ready", i), wrdy[i], 1);
            chk($sformatf("dut%0d rd_addr_ready", i), ardy[i], eq[i].size() < lat_of(i) + 1);
            chk($sformatf("dut%0d rd_data_valid", i), dv[i], ev);
            if (dv[i] && ev) chk($sformatf("dut%0d rd_data", i), dd[i], eq[i][0].data);

            if (rst) begin
                eq[i].delete();
            end else begin
                if (dv[i] && rr[i] && ev) begin
                    blog[i].push_back('{cyc, dd[i]});
                    void'(eq[i].pop_front());
                end
                if (rv[i] && ardy[i]) begin
                    if (int'(ra[i]) >= depth_of(i)) begin
                        ed = '0;
                    end else begin
                        ed = mm[i][ra[i]];
                        if (wf_of(i) && wv && w.addr == ra[i])
                            for (int b = 0; b < 2; b++)
                                if (w.be[b]) ed[b*8 +: 8] = w.data[b*8 +: 8];
                    end
                    eq[i].push_back('{cyc + lat_of(i), ed});
                    acc_cnt[i]++;
                end
                if (wv && int'(w.addr) < depth_of(i))
                    for (int b = 0; b < 2; b++)
                        if (w.be[b]) mm[i][w.addr][b*8 +: 8] = w.data[b*8 +: 8];
            end
        end
    end

    // ---- stimulus helpers ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setw(input logic v, input logic [W_ADDR-1:0] a,
                        input logic [W_DATA-1:0] d, input logic [1:0] be);
        wr_port_t w;
        w.be = be; w.data = d; w.addr = a;
        wbus = w;
        wv   = v;
    endtask

    task automatic rd_both(input logic v, input logic [W_ADDR-1:0] a);
        for (int i = 0; i < 2; i++) begin rv[i] = v; ra[i] = a; end
    endtask

    task automatic clr_log();
        for (int i = 0; i < 2; i++) blog[i].delete();
    endtask

    initial begin
        int c0;
        int base [2];
        rst = 1'b1; wv = 1'b0; wbus = '0;
        rv = '{1'b0, 1'b0}; ra = '{'0, '0}; rr = '{1'b1, 1'b1};
        repeat (3) tick();
        rst = 1'b0;

        // Fill every address (dut0 must drop the ones >= 1000).
        for (int a = 0; a < 1024; a++) begin
            setw(1'b1, W_ADDR'(a), 16'($urandom), 2'b11);
            tick();
        end
        wv = 1'b0;
        tick();

        // Back-to-back reads 0..7: consecutive beats from cycle c0+RD_LAT.
        for (int k = 0; k < 8; k++) begin
            setw(1'b1, W_ADDR'(k), 16'(16'h1000 + k), 2'b11);
            tick();
        end
        wv = 1'b0;
        tick();
        clr_log();
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            rd_both(1'b1, W_ADDR'(k));
            tick();
        end
        rd_both(1'b0, '0);
        repeat (8) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d b2b beats", i), blog[i].size(), 8);
            for (int k = 0; k < 8 && k < blog[i].size(); k++) begin
                chk($sformatf("dut%0d b2b cycle %0d", i, k), blog[i][k].cyc, c0 + lat_of(i) + k);
                chk($sformatf("dut%0d b2b data %0d", i, k), blog[i][k].data, 16'h1000 + k);
            end
        end

        // Write 0xBEEF@5, read 5 two cycles later.
        clr_log();
        setw(1'b1, 10'd5, 16'hBEEF, 2'b11);
        tick();
        wv = 1'b0;
        tick();
        c0 = cyc;
        rd_both(1'b1, 10'd5);
        tick();
        rd_both(1'b0, '0);
        repeat (6) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d beef beats", i), blog[i].size(), 1);
            if (blog[i].size() >= 1) begin
                chk($sformatf("dut%0d beef cycle", i), blog[i][0].cyc, c0 + lat_of(i));
                chk($sformatf("dut%0d beef data", i), blog[i][0].data, 16'hBEEF);
            end
        end

        // 10 reads against a 6-cycle rd_data stall.
        clr_log();
        rr = '{1'b0, 1'b0};
        base = acc_cnt;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 2; i++) begin
                rv[i] = (acc_cnt[i] - base[i]) < 10;
                ra[i] = W_ADDR'(20 + acc_cnt[i] - base[i]);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d stall accepts", i), acc_cnt[i] - base[i], lat_of(i) + 1);
            chk($sformatf("dut%0d stall addr_ready", i), ardy[i], 0);
        end
        rr = '{1'b1, 1'b1};
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 2; i++) begin
                rv[i] = (acc_cnt[i] - base[i]) < 10;
                ra[i] = W_ADDR'(20 + acc_cnt[i] - base[i]);
            end
            tick();
        end
        rd_both(1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d stall beats", i), blog[i].size(), 10);
            for (int k = 0; k < 10 && k < blog[i].size(); k++)
                chk($sformatf("dut%0d stall data %0d", i, k), blog[i][k].data, mm[i][20 + k]);
        end

        // Same-cycle collision on address 3.
        clr_log();
        setw(1'b1, 10'd3, 16'h1234, 2'b11);
        tick();
        setw(1'b1, 10'd3, 16'hABCD, 2'b01);
        rd_both(1'b1, 10'd3);
        tick();
        wv = 1'b0;
        rd_both(1'b0, '0);
        repeat (6) tick();
        chk("dut0 collision beats", blog[0].size(), 1);
        chk("dut1 collision beats", blog[1].size(), 1);
        if (blog[0].size() >= 1) chk("dut0 read_first data", blog[0][0].data, 16'h1234);
        if (blog[1].size() >= 1) chk("dut1 write_first data", blog[1][0].data, 16'h12CD);

        // Reset with two reads in flight; write during reset is ignored.
        clr_log();
        rr = '{1'b0, 1'b0};
        rd_both(1'b1, 10'd5);
        tick();
        rd_both(1'b1, 10'd6);
        tick();
        rd_both(1'b0, '0);
        rst = 1'b1;
        setw(1'b1, 10'd5, 16'h0BAD, 2'b11);
        tick();
        rst = 1'b0;
        wv  = 1'b0;
        rr  = '{1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d post-reset addr_ready", i), ardy[i], 1);
            chk($sformatf("dut%0d post-reset data_valid", i), dv[i], 0);
        end
        repeat (6) tick();
        for (int i = 0; i < 2; i++) chk($sformatf("dut%0d reset flushed beats", i), blog[i].size(), 0);
        rd_both(1'b1, 10'd5);
        tick();
        rd_both(1'b0, '0);
        repeat (6) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d post-reset beats", i), blog[i].size(), 1);
            if (blog[i].size() >= 1)
                chk($sformatf("dut%0d post-reset data", i), blog[i][0].data, 16'hBEEF);
        end

        // Address 1010: beyond dut0's DEPTH, inside dut1's.
        clr_log();
        setw(1'b1, 10'd1010, 16'h5A5A, 2'b11);
        tick();
        wv = 1'b0;
        rd_both(1'b1, 10'd1010);
        tick();
        rd_both(1'b0, '0);
        repeat (6) tick();
        chk("dut0 oob beats", blog[0].size(), 1);
        chk("dut1 oob beats", blog[1].size(), 1);
        if (blog[0].size() >= 1) chk("dut0 oob data", blog[0][0].data, 16'h0000);
        if (blog[1].size() >= 1) chk("dut1 in-range data", blog[1][0].data, 16'h5A5A);

        // Random traffic with collisions, back-pressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            logic [W_ADDR-1:0] wa;
            wa = W_ADDR'($urandom_range(0, 1023));
            setw(1'($urandom_range(0, 1)), wa, 16'($urandom), 2'($urandom_range(0, 3)));
            for (int i = 0; i < 2; i++) begin
                rv[i] = ($urandom_range(0, 9) < 6);
                ra[i] = ($urandom_range(0, 3) == 0) ? wa : W_ADDR'($urandom_range(0, 1023));
                rr[i] = ($urandom_range(0, 9) < 7);
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        wv  = 1'b0;
        rr  = '{1'b1, 1'b1};

        // Sweep every address so any stray write shows up.
        base = acc_cnt;
        for (int c = 0; c < 4000; c++) begin
            bit done;
            done = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (acc_cnt[i] - base[i] < 1024) begin
                    rv[i] = 1'b1;
                    ra[i] = W_ADDR'(acc_cnt[i] - base[i]);
                    done  = 1'b0;
                end else begin
                    rv[i] = 1'b0;
                end
            end
            if (done) break;
            tick();
        end
        rd_both(1'b0, '0);
        for (int i = 0; i < 2; i++) chk($sformatf("dut%0d sweep accepts", i), acc_cnt[i] - base[i], 1024);

        for (int c = 0; c < 100; c++) begin
            if (eq[0].size() == 0 && eq[1].size() == 0) break;
            tick();
        end
        for (int i = 0; i < 2; i++) chk($sformatf("dut%0d drained", i), eq[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
